// File: rtl/upc_loop_status_monitor.sv
// upc_loop_status_monitor
//
// Passive status monitor for one HLS-generated, non-dataflow kernel that holds a
// single pipelined loop. It watches the kernel block handshake and the loop
// FSM/pipeline-enable signals and keeps live counters and status flags. The
// block never drives the kernel.
//
// Optional feature: define UPC_STALL_COUNT_EN to add the stall_cnt output, which
// counts cycles the first pipeline stage is held by its subdone block while the
// loop runs.
//
// Ports:
//   clock, reset                   clock (rising edge) and async active-low reset
//   ap_start/ap_ready/ap_done/ap_continue   kernel block handshake
//   cur_state                      kernel FSM state vector
//   iter_start_state/iter_end_state/quit_state   FSM state constants
//   iter_start_block/iter_end_block/quit_block   stage subdone-block (1 = stalled)
//   iter_start_enable/iter_end_enable/quit_enable pipeline stage enables
//   loop_start/loop_ready/loop_done/loop_continue loop-level handshake
//   quit_at_end                    qualify loop exit with last-stage enable
//   finish                         freeze request, sticky until reset
//   mod_busy, loop_busy            transaction / loop in progress
//   mod_txn_cnt, iter_start_cnt, iter_end_cnt, loop_run_cnt   event counters
//   in_flight                      iterations started but not yet completed
//   last_loop_lat                  cycles spent in RUN by the latest loop run
//   stall_cnt                      first-stage stall cycles (UPC_STALL_COUNT_EN)
//   frozen                         finish has been captured

module upc_loop_status_monitor #(
    parameter int unsigned STATE_W = 1,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ap_start,
    input  logic               ap_ready,
    input  logic               ap_done,
    input  logic               ap_continue,
    input  logic [STATE_W-1:0] cur_state,
    input  logic [STATE_W-1:0] iter_start_state,
    input  logic [STATE_W-1:0] iter_end_state,
    input  logic [STATE_W-1:0] quit_state,
    input  logic               iter_start_block,
    input  logic               iter_end_block,
    input  logic               quit_block,
    input  logic               iter_start_enable,
    input  logic               iter_end_enable,
    input  logic               quit_enable,
    input  logic               loop_start,
    input  logic               loop_ready,
    input  logic               loop_done,
    input  logic               loop_continue,
    input  logic               quit_at_end,
    input  logic               finish,
    output logic               mod_busy,
    output logic               loop_busy,
    output logic [CNT_W-1:0]   mod_txn_cnt,
    output logic [CNT_W-1:0]   iter_start_cnt,
    output logic [CNT_W-1:0]   iter_end_cnt,
    output logic [CNT_W-1:0]   loop_run_cnt,
    output logic [CNT_W-1:0]   in_flight,
    output logic [CNT_W-1:0]   last_loop_lat,
`ifdef UPC_STALL_COUNT_EN
    output logic [CNT_W-1:0]   stall_cnt,
`endif
    output logic               frozen
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDoneWait
    } loop_state_e;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                 input logic              en);
        if (en && (value != CntMax)) begin
            return value + CntOne;
        end
        return value;
    endfunction

    // ------------------------------------------------------------------
    // Per-cycle events
    // ------------------------------------------------------------------
    logic st_ev;
    logic end_ev;
    logic quit_ev;
    logic mod_done;

    assign st_ev    = (cur_state == iter_start_state) & iter_start_enable & ~iter_start_block;
    assign end_ev   = (cur_state == iter_end_state) & iter_end_enable & ~iter_end_block;
    assign quit_ev  = (cur_state == quit_state) & ~quit_block & (quit_at_end ? quit_enable : 1'b1);
    assign mod_done = ap_done & ap_continue;

    // quit_ev is a cycle-level observation only; it and the ready strobes feed
    // no state.
    logic unused_obs;
    assign unused_obs = ^{quit_ev, ap_ready, loop_ready};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    loop_state_e      state_q, state_d;
    logic             mod_busy_q, mod_busy_d;
    logic             frozen_q, frozen_d;
    logic [CNT_W-1:0] mod_txn_cnt_q, mod_txn_cnt_d;
    logic [CNT_W-1:0] iter_start_cnt_q, iter_start_cnt_d;
    logic [CNT_W-1:0] iter_end_cnt_q, iter_end_cnt_d;
    logic [CNT_W-1:0] loop_run_cnt_q, loop_run_cnt_d;
    logic [CNT_W-1:0] last_loop_lat_q, last_loop_lat_d;

    // ------------------------------------------------------------------
    // Next-state logic. Everything but the freeze flag itself is gated by
    // frozen_q, so an event coinciding with finish is still counted.
    // ------------------------------------------------------------------
    always_comb begin
        state_d          = state_q;
        mod_busy_d       = mod_busy_q;
        frozen_d         = frozen_q | finish;
        mod_txn_cnt_d    = mod_txn_cnt_q;
        iter_start_cnt_d = iter_start_cnt_q;
        iter_end_cnt_d   = iter_end_cnt_q;
        loop_run_cnt_d   = loop_run_cnt_q;
        last_loop_lat_d  = last_loop_lat_q;

        if (!frozen_q) begin
            // Module tracker: done/continue wins over start, so a start and
            // done in the same idle cycle is a zero-length transaction.
            if (mod_done) begin
                mod_busy_d = 1'b0;
            end else if (ap_start && !mod_busy_q) begin
                mod_busy_d = 1'b1;
            end
            mod_txn_cnt_d = sat_inc(mod_txn_cnt_q, mod_done);

            iter_start_cnt_d = sat_inc(iter_start_cnt_q, st_ev);
            iter_end_cnt_d   = sat_inc(iter_end_cnt_q, end_ev);

            case (state_q)
                StIdle: begin
                    if (loop_start) begin
                        state_d         = StRun;
                        last_loop_lat_d = '0;
                    end
                end
                StRun: begin
                    // The cycle that sees loop_done is still a RUN cycle.
                    last_loop_lat_d = sat_inc(last_loop_lat_q, 1'b1);
                    if (loop_done) begin
                        if (loop_continue) begin
                            state_d        = StIdle;
                            loop_run_cnt_d = sat_inc(loop_run_cnt_q, 1'b1);
                        end else begin
                            state_d = StDoneWait;
                        end
                    end
                end
                StDoneWait: begin
                    if (loop_continue) begin
                        state_d        = StIdle;
                        loop_run_cnt_d = sat_inc(loop_run_cnt_q, 1'b1);
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q          <= StIdle;
            mod_busy_q       <= 1'b0;
            frozen_q         <= 1'b0;
            mod_txn_cnt_q    <= '0;
            iter_start_cnt_q <= '0;
            iter_end_cnt_q   <= '0;
            loop_run_cnt_q   <= '0;
            last_loop_lat_q  <= '0;
        end else begin
            state_q          <= state_d;
            mod_busy_q       <= mod_busy_d;
            frozen_q         <= frozen_d;
            mod_txn_cnt_q    <= mod_txn_cnt_d;
            iter_start_cnt_q <= iter_start_cnt_d;
            iter_end_cnt_q   <= iter_end_cnt_d;
            loop_run_cnt_q   <= loop_run_cnt_d;
            last_loop_lat_q  <= last_loop_lat_d;
        end
    end

`ifdef UPC_STALL_COUNT_EN
    // ------------------------------------------------------------------
    // Stall counter: first stage selected and enabled but held by its block.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             stall_ev;

    assign stall_ev = (state_q != StIdle) & ~frozen_q & (cur_state == iter_start_state)
                      & iter_start_enable & iter_start_block;

    always_comb begin
        stall_cnt_d = sat_inc(stall_cnt_q, stall_ev);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    // No stall counter in this build.
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mod_busy       = mod_busy_q;
    assign loop_busy      = (state_q != StIdle);
    assign frozen         = frozen_q;
    assign mod_txn_cnt    = mod_txn_cnt_q;
    assign iter_start_cnt = iter_start_cnt_q;
    assign iter_end_cnt   = iter_end_cnt_q;
    assign loop_run_cnt   = loop_run_cnt_q;
    assign last_loop_lat  = last_loop_lat_q;
    // Plain modulo difference of the registered counters.
    assign in_flight      = iter_start_cnt_q - iter_end_cnt_q;

endmodule

// File: tb/tb_upc_loop_status_monitor.sv
// Bench for upc_loop_status_monitor: two instances (wide and 4-bit counters)
// share one stimulus; a behavioural model keeps unbounded event tallies and
// derives saturated/modulo expectations per instance width.

module tb_upc_loop_status_monitor;

    localparam int unsigned StateW = 2;
    localparam int unsigned MainW  = 16;
    localparam int unsigned SatW   = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic              reset;
    logic              ap_start, ap_ready, ap_done, ap_continue;
    logic [StateW-1:0] cur_state, iter_start_state, iter_end_state, quit_state;
    logic              iter_start_block, iter_end_block, quit_block;
    logic              iter_start_enable, iter_end_enable, quit_enable;
    logic              loop_start, loop_ready, loop_done, loop_continue;
    logic              quit_at_end, finish;

    logic              main_mod_busy, main_loop_busy, main_frozen;
    logic [MainW-1:0]  main_txn, main_ist, main_iend, main_runs, main_infl, main_lat, main_stall;
    logic              sat_mod_busy, sat_loop_busy, sat_frozen;
    logic [SatW-1:0]   sat_txn, sat_ist, sat_iend, sat_runs, sat_infl, sat_lat, sat_stall;

    upc_loop_status_monitor #(.STATE_W(StateW), .CNT_W(MainW)) u_main (
        .clock             (clock),
        .reset             (reset),
        .ap_start          (ap_start),
        .ap_ready          (ap_ready),
        .ap_done           (ap_done),
        .ap_continue       (ap_continue),
        .cur_state         (cur_state),
        .iter_start_state  (iter_start_state),
        .iter_end_state    (iter_end_state),
        .quit_state        (quit_state),
        .iter_start_block  (iter_start_block),
        .iter_end_block    (iter_end_block),
        .quit_block        (quit_block),
        .iter_start_enable (iter_start_enable),
        .iter_end_enable   (iter_end_enable),
        .quit_enable       (quit_enable),
        .loop_start        (loop_start),
        .loop_ready        (loop_ready),
        .loop_done         (loop_done),
        .loop_continue     (loop_continue),
        .quit_at_end       (quit_at_end),
        .finish            (finish),
        .mod_busy          (main_mod_busy),
        .loop_busy         (main_loop_busy),
        .mod_txn_cnt       (main_txn),
        .iter_start_cnt    (main_ist),
        .iter_end_cnt      (main_iend),
        .loop_run_cnt      (main_runs),
        .in_flight         (main_infl),
        .last_loop_lat     (main_lat),
`ifdef UPC_STALL_COUNT_EN
        .stall_cnt         (main_stall),
`endif
        .frozen            (main_frozen)
    );

    upc_loop_status_monitor #(.STATE_W(StateW), .CNT_W(SatW)) u_sat (
        .clock             (clock),
        .reset             (reset),
        .ap_start          (ap_start),
        .ap_ready          (ap_ready),
        .ap_done           (ap_done),
        .ap_continue       (ap_continue),
        .cur_state         (cur_state),
        .iter_start_state  (iter_start_state),
        .iter_end_state    (iter_end_state),
        .quit_state        (quit_state),
        .iter_start_block  (iter_start_block),
        .iter_end_block    (iter_end_block),
        .quit_block        (quit_block),
        .iter_start_enable (iter_start_enable),
        .iter_end_enable   (iter_end_enable),
        .quit_enable       (quit_enable),
        .loop_start        (loop_start),
        .loop_ready        (loop_ready),
        .loop_done         (loop_done),
        .loop_continue     (loop_continue),
        .quit_at_end       (quit_at_end),
        .finish            (finish),
        .mod_busy          (sat_mod_busy),
        .loop_busy         (sat_loop_busy),
        .mod_txn_cnt       (sat_txn),
        .iter_start_cnt    (sat_ist),
        .iter_end_cnt      (sat_iend),
        .loop_run_cnt      (sat_runs),
        .in_flight         (sat_infl),
        .last_loop_lat     (sat_lat),
`ifdef UPC_STALL_COUNT_EN
        .stall_cnt         (sat_stall),
`endif
        .frozen            (sat_frozen)
    );

`ifndef UPC_STALL_COUNT_EN
    assign main_stall = '0;
    assign sat_stall  = '0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: unbounded event tallies; saturation and modulo are
    // applied only when forming an expectation for a given counter width.
    // ------------------------------------------------------------------
    longint r_txn, r_st, r_end, r_runs, r_lat, r_stall;
    bit     r_busy, r_in_loop, r_wait_cont, r_frozen;

    function automatic longint cap(input longint v, input int w);
        longint mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic longint infl(input int w);
        longint mx = (longint'(1) << w) - 1;
        return (cap(r_st, w) - cap(r_end, w)) & mx;
    endfunction

    task automatic model_reset();
        r_txn = 0; r_st = 0; r_end = 0; r_runs = 0; r_lat = 0; r_stall = 0;
        r_busy = 0; r_in_loop = 0; r_wait_cont = 0; r_frozen = 0;
    endtask

    task automatic model_step();
        bit st, en;
        if (!r_frozen) begin
            st = (cur_state == iter_start_state) && iter_start_enable && !iter_start_block;
            en = (cur_state == iter_end_state) && iter_end_enable && !iter_end_block;
            if (st) r_st++;
            if (en) r_end++;
            if (ap_done && ap_continue) begin
                r_txn++;
                r_busy = 0;
            end else if (ap_start) begin
                r_busy = 1;
            end
            if (r_in_loop && (cur_state == iter_start_state) && iter_start_enable
                && iter_start_block) r_stall++;
            if (!r_in_loop) begin
                if (loop_start) begin
                    r_in_loop = 1;
                    r_lat     = 0;
                end
            end else if (r_wait_cont) begin
                if (loop_continue) begin
                    r_in_loop   = 0;
                    r_wait_cont = 0;
                    r_runs++;
                end
            end else begin
                r_lat++;
                if (loop_done && loop_continue) begin
                    r_in_loop = 0;
                    r_runs++;
                end else if (loop_done) begin
                    r_wait_cont = 1;
                end
            end
        end
        if (finish) r_frozen = 1;
    endtask

    task automatic check_all(input string ph);
        check_eq({ph, "/mod_busy"},  main_mod_busy,  r_busy);
        check_eq({ph, "/loop_busy"}, main_loop_busy, r_in_loop);
        check_eq({ph, "/frozen"},    main_frozen,    r_frozen);
        check_eq({ph, "/txn"},       main_txn,       cap(r_txn, MainW));
        check_eq({ph, "/ist"},       main_ist,       cap(r_st, MainW));
        check_eq({ph, "/iend"},      main_iend,      cap(r_end, MainW));
        check_eq({ph, "/runs"},      main_runs,      cap(r_runs, MainW));
        check_eq({ph, "/infl"},      main_infl,      infl(MainW));
        check_eq({ph, "/lat"},       main_lat,       cap(r_lat, MainW));
        check_eq({ph, "/s.busy"},    sat_loop_busy,  r_in_loop);
        check_eq({ph, "/s.mbusy"},   sat_mod_busy,   r_busy);
        check_eq({ph, "/s.frozen"},  sat_frozen,     r_frozen);
        check_eq({ph, "/s.txn"},     sat_txn,        cap(r_txn, SatW));
        check_eq({ph, "/s.ist"},     sat_ist,        cap(r_st, SatW));
        check_eq({ph, "/s.iend"},    sat_iend,       cap(r_end, SatW));
        check_eq({ph, "/s.runs"},    sat_runs,       cap(r_runs, SatW));
        check_eq({ph, "/s.infl"},    sat_infl,       infl(SatW));
        check_eq({ph, "/s.lat"},     sat_lat,        cap(r_lat, SatW));
`ifdef UPC_STALL_COUNT_EN
        check_eq({ph, "/stall"},     main_stall,     cap(r_stall, MainW));
        check_eq({ph, "/s.stall"},   sat_stall,      cap(r_stall, SatW));
`endif
    endtask

    // Inputs change just after the falling edge; outputs are checked there too.
    task automatic cycle();
        if (reset) model_step();
        @(posedge clock);
        @(negedge clock);
        check_all("cyc");
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check_all("rst");
        repeat (2) cycle();
        reset = 1'b1;
    endtask

    task automatic drive_idle();
        ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0;
        cur_state = 2'd1; iter_start_state = 2'd1; iter_end_state = 2'd1; quit_state = 2'd1;
        iter_start_block = 0; iter_end_block = 0; quit_block = 0;
        iter_start_enable = 0; iter_end_enable = 0; quit_enable = 0;
        loop_start = 0; loop_ready = 0; loop_done = 0; loop_continue = 0;
        quit_at_end = 0; finish = 0;
    endtask

    // 8 iterations through a 3-stage II=1 pipeline. Pipeline advance a starts
    // iteration a (a = 0..7, the first together with loop_start) and retires
    // iteration a-3, so three iterations are counted in flight at the peak and
    // the loop spends 10 advancing cycles in RUN. Stall cycles freeze the pipe.
    task automatic run_pipe(input int stalls, input string ph);
        longint peak = 0;
        for (int a = 0; a <= 10; a++) begin
            ap_start          = (a == 0);
            loop_start        = (a == 0);
            iter_start_enable = (a <= 7);
            iter_end_enable   = (a >= 3);
            iter_start_block  = 0;
            iter_end_block    = 0;
            loop_done         = (a == 10);
            loop_continue     = (a == 10);
            ap_done           = (a == 10);
            ap_continue       = (a == 10);
            cycle();
            if (longint'(main_infl) > peak) peak = longint'(main_infl);
            if (a == 4) begin
                for (int s = 0; s < stalls; s++) begin
                    ap_start = 0; loop_start = 0;
                    iter_start_enable = 1; iter_start_block = 1;
                    iter_end_enable   = 1; iter_end_block   = 1;
                    cycle();
                    if (longint'(main_infl) > peak) peak = longint'(main_infl);
                end
            end
        end
        drive_idle();
        cycle();
        check_eq({ph, ".ist"},  main_ist,  8);
        check_eq({ph, ".iend"}, main_iend, 8);
        check_eq({ph, ".peak"}, peak,      3);
        check_eq({ph, ".runs"}, main_runs, 1);
        check_eq({ph, ".txn"},  main_txn,  1);
        check_eq({ph, ".lat"},  main_lat,  10 + stalls);
        check_eq({ph, ".busy"}, main_mod_busy, 0);
`ifdef UPC_STALL_COUNT_EN
        check_eq({ph, ".stall"}, main_stall, stalls);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        reset = 1'b1;
        apply_reset();

        // Reset mid-run with nonzero counters.
        loop_start = 1; iter_start_enable = 1; ap_start = 1;
        cycle();
        loop_start = 0; ap_start = 0;
        repeat (3) cycle();
        check_eq("pre_rst.ist", main_ist, 4);
        apply_reset();
        check_eq("rst.ist",   main_ist,       0);
        check_eq("rst.lbusy", main_loop_busy, 0);
        check_eq("rst.mbusy", main_mod_busy,  0);
        check_eq("rst.lat",   main_lat,       0);
        drive_idle();
        cycle();
        check_eq("rel.lbusy", main_loop_busy, 0);

        // Clean 8-iteration run, then the same with four stall cycles.
        apply_reset();
        run_pipe(0, "pipe");
        apply_reset();
        run_pipe(4, "stall");

        // Continue backpressure.
        apply_reset();
        drive_idle();
        loop_start = 1;
        cycle();
        loop_start = 0;
        cycle();
        loop_done = 1; loop_continue = 0;
        repeat (3) cycle();
        check_eq("bp.lbusy", main_loop_busy, 1);
        check_eq("bp.runs",  main_runs,      0);
        loop_done = 0; loop_continue = 1;
        cycle();
        check_eq("bp.runs_after",  main_runs,      1);
        check_eq("bp.lbusy_after", main_loop_busy, 0);

        // Freeze after five iteration starts; finish coincides with the fifth.
        apply_reset();
        drive_idle();
        iter_start_enable = 1;
        for (int i = 0; i < 5; i++) begin
            finish = (i == 4);
            cycle();
        end
        finish = 0;
        repeat (4) cycle();
        check_eq("frz.flag", main_frozen, 1);
        check_eq("frz.ist",  main_ist,    5);

        // Saturation of the 4-bit instance.
        apply_reset();
        drive_idle();
        iter_start_enable = 1;
        repeat (20) cycle();
        check_eq("sat.ist4",  sat_ist,  15);
        check_eq("sat.ist16", main_ist, 20);
        drive_idle();

        // Randomized traffic against the model.
        for (int blk = 0; blk < 4; blk++) begin
            drive_idle();
            apply_reset();
            iter_start_state = StateW'($urandom_range(0, 3));
            iter_end_state   = StateW'($urandom_range(0, 3));
            quit_state       = StateW'($urandom_range(0, 3));
            for (int c = 0; c < 600; c++) begin
                ap_start          = ($urandom_range(0, 99) < 20);
                ap_ready          = ($urandom_range(0, 99) < 20);
                ap_done           = ($urandom_range(0, 99) < 15);
                ap_continue       = ($urandom_range(0, 99) < 70);
                cur_state         = StateW'($urandom_range(0, 3));
                iter_start_enable = ($urandom_range(0, 99) < 80);
                iter_end_enable   = ($urandom_range(0, 99) < 80);
                quit_enable       = ($urandom_range(0, 99) < 50);
                iter_start_block  = ($urandom_range(0, 99) < 25);
                iter_end_block    = ($urandom_range(0, 99) < 25);
                quit_block        = ($urandom_range(0, 99) < 25);
                loop_start        = ($urandom_range(0, 99) < 10);
                loop_ready        = ($urandom_range(0, 99) < 10);
                loop_done         = ($urandom_range(0, 99) < 10);
                loop_continue     = ($urandom_range(0, 99) < 60);
                quit_at_end       = ($urandom_range(0, 1) == 1);
                finish            = (c > 400) && ($urandom_range(0, 999) < 10);
                if ($urandom_range(0, 999) < 3) apply_reset();
                else cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
